// File: rtl/spi_dac_nx_pkg.sv
// Shared types, frame builder and parameter limits for the spi_dac_nx DAC loader.
package spi_dac_nx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int FRAME_MAX        = 64;
  localparam int MIN_CLK_DIV      = 1;
  localparam int MIN_CS_IDLE      = 1;
  localparam int MIN_CS_IDLE_LDAC = 2;

  // {zeros, payload, lsb_pad zeros}, right-aligned in a FRAME_MAX word
  function automatic logic [FRAME_MAX-1:0] build_frame(
    input logic [FRAME_MAX-1:0] payload,
    input int                   data_w,
    input int                   lsb_pad,
    input int                   frame_w
  );
    logic [FRAME_MAX-1:0] pay_mask;
    logic [FRAME_MAX-1:0] frm_mask;
    pay_mask = {FRAME_MAX{1'b1}} >> (FRAME_MAX - data_w);
    frm_mask = {FRAME_MAX{1'b1}} >> (FRAME_MAX - frame_w);
    return ((payload & pay_mask) << lsb_pad) & frm_mask;
  endfunction

  function automatic bit frame_fits(input int data_w, input int lsb_pad, input int frame_w);
    return (data_w >= 1) && (frame_w >= 2) && (frame_w <= FRAME_MAX) &&
           (lsb_pad >= 0) && (lsb_pad + data_w <= frame_w);
  endfunction

endpackage

// File: rtl/spi_dac_nx_sclk_gen.sv
// SCLK generator: CLK_DIV cycles per half-period, low half first; held low and
// reset while disabled. Rise/fall strobes flag the edge at which sclk toggles.
module spi_dac_nx_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (i_rst || !i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_sclk = r_sclk;
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick &&  r_sclk;

endmodule

// File: rtl/spi_dac_nx.sv
// Multi-channel serial DAC loader: one frame per handshake, all channels shifted
// MSB-first in parallel. Optional LDAC strobe under SPI_DAC_NX_LDAC_EN.
module spi_dac_nx
  import spi_dac_nx_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int FRAME_W  = 16,
  parameter int LSB_PAD  = 4,
  parameter int CLK_DIV  = 1,
  parameter int CS_IDLE  = 2
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [CHANNELS*DATA_W-1:0]   i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [CHANNELS-1:0]          o_dac_data,
  output logic                         o_dac_sclk,
  output logic                         o_dac_cs_n,
  output logic                         o_done
`ifdef SPI_DAC_NX_LDAC_EN
  ,
  output logic                         o_dac_ldac_n
`endif
);

  localparam int BW = $clog2(FRAME_W + 1);
  localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  if (!frame_fits(DATA_W, LSB_PAD, FRAME_W)) begin : g_chk_frame
    $error("spi_dac_nx: LSB_PAD+DATA_W must fit in FRAME_W");
  end
  if (CLK_DIV < MIN_CLK_DIV || CS_IDLE < MIN_CS_IDLE) begin : g_chk_timing
    $error("spi_dac_nx: CLK_DIV and CS_IDLE must be >= 1");
  end

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic          r_cs_n, w_cs_n_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_done, w_done_nxt;
  logic          w_load, w_shift;
  logic          w_en, w_sclk, w_rise, w_fall;

  assign w_en = (r_state == SHIFT);

  spi_dac_nx_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_en   (w_en),
    .o_sclk (w_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_gap   <= '0;
      r_cs_n  <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_gap   <= w_gap_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Bit counter drops on each rise; the fall after the last rise closes the frame
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    w_cs_n_nxt  = r_cs_n;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        if (r_ready && i_valid) begin
          w_state_nxt = SHIFT;
          w_cs_n_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          w_load      = 1'b1;
          w_bit_nxt   = BW'(FRAME_W);
        end
      end
      SHIFT: begin
        if (w_rise) w_bit_nxt = r_bit - BW'(1);
        if (w_fall) begin
          w_shift = 1'b1;
          if (r_bit == '0) begin
            w_state_nxt = GAP;
            w_cs_n_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
            w_gap_nxt   = GW'(CS_IDLE - 1);
          end
        end
      end
      GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
        end else begin
          w_gap_nxt = r_gap - GW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Zero fill means the register is empty once the last bit leaves
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [FRAME_W-1:0] r_sh;
    always_ff @(posedge clk) begin
      if (i_rst)
        r_sh <= '0;
      else if (w_load)
        r_sh <= FRAME_W'(build_frame(FRAME_MAX'(i_data[c*DATA_W +: DATA_W]),
                                     DATA_W, LSB_PAD, FRAME_W));
      else if (w_shift)
        r_sh <= {r_sh[FRAME_W-2:0], 1'b0};
    end
    assign o_dac_data[c] = r_sh[FRAME_W-1];
  end

  assign o_ready    = r_ready;
  assign o_dac_sclk = w_sclk;
  assign o_dac_cs_n = r_cs_n;
  assign o_done     = r_done;

`ifdef SPI_DAC_NX_LDAC_EN
  if (CS_IDLE < MIN_CS_IDLE_LDAC) begin : g_chk_ldac
    $error("spi_dac_nx: LDAC strobe needs CS_IDLE >= 2");
  end

  logic r_ldac_n;
  // r_done marks the first GAP cycle, so the strobe lands on the second
  always_ff @(posedge clk) begin
    if (i_rst) r_ldac_n <= 1'b1;
    else       r_ldac_n <= !((r_state == GAP) && r_done);
  end
  assign o_dac_ldac_n = r_ldac_n;
`endif

endmodule

// File: tb/tb_spi_dac_nx.sv
// Scoreboard bench for spi_dac_nx: default instance plus a CLK_DIV=3 / 12-bit instance.
module tb_spi_dac_nx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- instance A: defaults ----------------
  logic [31:0] a_data;
  logic        a_valid, a_ready, a_sclk, a_cs_n, a_done;
  logic [3:0]  a_dd;
`ifdef SPI_DAC_NX_LDAC_EN
  logic        a_ldac_n;
`endif

  spi_dac_nx #(.CHANNELS(4), .DATA_W(8), .FRAME_W(16), .LSB_PAD(4), .CLK_DIV(1), .CS_IDLE(2)) u_a (
    .clk(clk), .i_rst(rst), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
    .o_dac_data(a_dd), .o_dac_sclk(a_sclk), .o_dac_cs_n(a_cs_n), .o_done(a_done)
`ifdef SPI_DAC_NX_LDAC_EN
    , .o_dac_ldac_n(a_ldac_n)
`endif
  );

  // ---------------- instance B: slow clock, full-width payload ----------------
  logic [23:0] b_data;
  logic        b_valid, b_ready, b_sclk, b_cs_n, b_done;
  logic [1:0]  b_dd;
`ifdef SPI_DAC_NX_LDAC_EN
  logic        b_ldac_n;
`endif

  spi_dac_nx #(.CHANNELS(2), .DATA_W(12), .FRAME_W(12), .LSB_PAD(0), .CLK_DIV(3), .CS_IDLE(2)) u_b (
    .clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
    .o_dac_data(b_dd), .o_dac_sclk(b_sclk), .o_dac_cs_n(b_cs_n), .o_done(b_done)
`ifdef SPI_DAC_NX_LDAC_EN
    , .o_dac_ldac_n(b_ldac_n)
`endif
  );

  typedef struct packed {
    logic [3:0][15:0] fr;
    int               hs;
    logic             b2b;
  } exp_a_t;

  exp_a_t           qa[$];
  logic [1:0][11:0] qb[$];

  // directed vectors: payloads ch3..ch0 and hand-computed frames ch3..ch0
  logic [31:0] vd[5];
  logic [63:0] vf[5];
  initial begin
    vd = '{32'hA53CFF01, 32'h12345678, 32'h80FF007F, 32'hC3965AE1, 32'h0F1E2D3C};
    vf = '{64'h0A50_03C0_0FF0_0010, 64'h0120_0340_0560_0780, 64'h0800_0FF0_0000_07F0,
           64'h0C30_0960_05A0_0E10, 64'h00F0_01E0_02D0_03C0};
  end

  // ---------------- monitor A ----------------
  initial begin : mon_a
    logic             pcs, psclk, pready, rise;
    logic [3:0][15:0] cap;
    int               nb, csl, fall_c, last_fall, last_rise, pend;
    exp_a_t           e;
    pcs = 1'b1; psclk = 1'b0; pready = 1'b0; cap = '0;
    nb = 0; csl = 0; fall_c = 0; last_fall = -1000; last_rise = -1000; pend = -1;
    forever begin
      @(posedge clk); #1;
`ifdef SPI_DAC_NX_LDAC_EN
      if (!a_ldac_n || cyc == last_rise + 1)
        chk("ldac_n", 64'(a_ldac_n), (cyc == last_rise + 1) ? 64'd0 : 64'd1);
`endif
      if (rst) begin
        cap = '0; nb = 0; pend = -1; rise = 1'b0;
      end else begin
        rise = a_cs_n && !pcs;
        if (!a_cs_n) begin
          if (pcs) begin fall_c = cyc; csl = 1; nb = 0; cap = '0; end
          else csl++;
          if (a_sclk && !psclk) begin
            for (int c = 0; c < 4; c++) cap[c] = {cap[c][14:0], a_dd[c]};
            nb++;
          end
        end
        if (a_done || rise) chk("done_at_cs_rise", 64'(a_done), 64'(rise));
        if (rise) begin
          if (qa.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
          else begin
            e = qa.pop_front();
            for (int c = 0; c < 4; c++) chk($sformatf("frame_ch%0d", c), 64'(cap[c]), 64'(e.fr[c]));
            chk("bits_per_frame", 64'(nb), 64'd16);
            chk("cs_low_cycles", 64'(csl), 64'd32);
            chk("cs_fall_cycle", 64'(fall_c), 64'(e.hs + 1));
            chk("done_cycle", 64'(cyc), 64'(e.hs + 33));
            if (e.b2b) chk("b2b_period", 64'(fall_c - last_fall), 64'd35);
            last_fall = fall_c;
            last_rise = cyc;
            pend      = e.hs + 35;
          end
        end
        if (a_ready && !pready && pend >= 0) begin
          chk("ready_cycle", 64'(cyc), 64'(pend));
          pend = -1;
        end
      end
      pcs = a_cs_n; psclk = a_sclk; pready = a_ready;
    end
  end

  // ---------------- monitor B ----------------
  int b_ldac_lows = 0;
  initial begin : mon_b
    logic             pcs, psclk;
    logic [1:0]       pdd;
    logic [1:0][11:0] cap;
    logic [1:0][11:0] eb;
    int               nb, csl, run, hmin, hmax, lmin, lmax, unstable;
    pcs = 1'b1; psclk = 1'b0; pdd = '0; cap = '0;
    nb = 0; csl = 0; run = 0; hmin = 1000; hmax = 0; lmin = 1000; lmax = 0; unstable = 0;
    forever begin
      @(posedge clk); #1;
`ifdef SPI_DAC_NX_LDAC_EN
      if (!b_ldac_n) b_ldac_lows++;
`endif
      if (!rst) begin
        if (!pcs) begin
          if (b_sclk != psclk) begin
            if (b_sclk) begin lmin = (run < lmin) ? run : lmin; lmax = (run > lmax) ? run : lmax; end
            else        begin hmin = (run < hmin) ? run : hmin; hmax = (run > hmax) ? run : hmax; end
            run = 1;
          end else run++;
          if (b_sclk && b_dd != pdd) unstable++;
        end
        if (!b_cs_n) begin
          if (pcs) begin
            csl = 1; nb = 0; cap = '0; run = 1;
            hmin = 1000; hmax = 0; lmin = 1000; lmax = 0; unstable = 0;
          end else csl++;
          if (b_sclk && !psclk) begin
            for (int c = 0; c < 2; c++) cap[c] = {cap[c][10:0], b_dd[c]};
            nb++;
          end
        end
        if (b_cs_n && !pcs) begin
          if (qb.size() == 0) chk("b_unexpected_frame", 64'd1, 64'd0);
          else begin
            eb = qb.pop_front();
            chk("b_frame_ch0", 64'(cap[0]), 64'(eb[0]));
            chk("b_frame_ch1", 64'(cap[1]), 64'(eb[1]));
            chk("b_bits", 64'(nb), 64'd12);
            chk("b_cs_low_cycles", 64'(csl), 64'd72);
            chk("b_sclk_high_min", 64'(hmin), 64'd3);
            chk("b_sclk_high_max", 64'(hmax), 64'd3);
            chk("b_sclk_low_min", 64'(lmin), 64'd3);
            chk("b_sclk_low_max", 64'(lmax), 64'd3);
            chk("b_data_stable", 64'(unstable), 64'd0);
          end
        end
      end
      pcs = b_cs_n; psclk = b_sclk; pdd = b_dd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_a(input logic [31:0] d, input logic [63:0] f, input bit keep, input bit b2b);
    exp_a_t e;
    bit     ok;
    ok = 1'b0;
    a_data  = d;
    a_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (a_ready) begin
        e.fr = f; e.hs = cyc; e.b2b = b2b;
        qa.push_back(e);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) chk("a_ready_timeout", 64'd0, 64'd1);
    if (!keep || !ok) a_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (qa.size() == 0 && qb.size() == 0) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    rst = 1'b1; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(a_cs_n), 64'd1);
    chk("rst_sclk", 64'(a_sclk), 64'd0);
    chk("rst_data", 64'(a_dd), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd0);
`ifdef SPI_DAC_NX_LDAC_EN
    chk("rst_ldac_n", 64'(a_ldac_n), 64'd1);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(a_ready), 64'd1);

    // single frame with the reference payload
    send_a(vd[0], vf[0], 1'b0, 1'b0);
    drain();

    // valid held high, data changing each frame
    send_a(vd[1], vf[1], 1'b1, 1'b0);
    send_a(vd[2], vf[2], 1'b1, 1'b1);
    send_a(vd[3], vf[3], 1'b0, 1'b1);
    drain();

    // slow-clock instance
    b_data  = {12'h800, 12'h001};
    b_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (b_ready) begin qb.push_back({12'h800, 12'h001}); ok = 1'b1; end
      @(negedge clk);
    end
    if (!ok) chk("b_ready_timeout", 64'd0, 64'd1);
    b_valid = 1'b0;
    drain();
`ifdef SPI_DAC_NX_LDAC_EN
    chk("b_ldac_pulses", 64'(b_ldac_lows), 64'd1);
`endif

    // reset during bit 7 of a frame
    send_a(vd[3], vf[3], 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    chk("mid_frame_cs_n", 64'(a_cs_n), 64'd0);
    rst = 1'b1;
    qa.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs_n", 64'(a_cs_n), 64'd1);
    chk("abort_sclk", 64'(a_sclk), 64'd0);
    chk("abort_data", 64'(a_dd), 64'd0);
    chk("abort_done", 64'(a_done), 64'd0);
    chk("abort_ready", 64'(a_ready), 64'd0);
`ifdef SPI_DAC_NX_LDAC_EN
    chk("abort_ldac_n", 64'(a_ldac_n), 64'd1);
`endif
    @(negedge clk);
    chk("ready_after_abort", 64'(a_ready), 64'd1);
    send_a(vd[4], vf[4], 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
